// File: rtl/fpu_rptr_pkg.sv
// Shared constants for the FPU result-bus repeater/arbiter: source tags and default width.
package fpu_rptr_pkg;

  localparam int unsigned FPU_RPTR_WIDTH = 64;

  typedef logic [1:0] fpu_rptr_src_t;

  localparam fpu_rptr_src_t FPU_RPTR_SRC_ADD = 2'b00;
  localparam fpu_rptr_src_t FPU_RPTR_SRC_MUL = 2'b01;
  localparam fpu_rptr_src_t FPU_RPTR_SRC_DIV = 2'b10;

  // Round-robin successor: add -> mul -> div -> add.
  function automatic fpu_rptr_src_t fpu_rptr_next_src(input fpu_rptr_src_t src);
    case (src)
      FPU_RPTR_SRC_ADD: return FPU_RPTR_SRC_MUL;
      FPU_RPTR_SRC_MUL: return FPU_RPTR_SRC_DIV;
      default:          return FPU_RPTR_SRC_ADD;
    endcase
  endfunction

endpackage

// File: rtl/fpu_rptr_arb_if.sv
// Handshake bundle between the three FPU pipes, the repeater and the downstream result route.
interface fpu_rptr_arb_if
  import fpu_rptr_pkg::*;
#(
  parameter int unsigned WIDTH = FPU_RPTR_WIDTH
);
  logic             add_req_vld;
  logic [WIDTH-1:0] add_req_data;
  logic             add_req_rdy;
  logic             mul_req_vld;
  logic [WIDTH-1:0] mul_req_data;
  logic             mul_req_rdy;
  logic             div_req_vld;
  logic [WIDTH-1:0] div_req_data;
  logic             div_req_rdy;
  logic             rptr_out_vld;
  logic [WIDTH-1:0] rptr_out_data;
  fpu_rptr_src_t    rptr_out_src;
  logic             rptr_out_rdy;

  // Repeater side.
  modport slave (
    input  add_req_vld, add_req_data, mul_req_vld, mul_req_data, div_req_vld, div_req_data,
    input  rptr_out_rdy,
    output add_req_rdy, mul_req_rdy, div_req_rdy,
    output rptr_out_vld, rptr_out_data, rptr_out_src
  );

  // Pipe/downstream side.
  modport master (
    output add_req_vld, add_req_data, mul_req_vld, mul_req_data, div_req_vld, div_req_data,
    output rptr_out_rdy,
    input  add_req_rdy, mul_req_rdy, div_req_rdy,
    input  rptr_out_vld, rptr_out_data, rptr_out_src
  );
endinterface

// File: rtl/fpu_rptr_stage.sv
// One valid/data/src register slice; accepts when empty or when its content drains this cycle.
module fpu_rptr_stage
  import fpu_rptr_pkg::*;
#(
  parameter int unsigned WIDTH = FPU_RPTR_WIDTH
) (
  input  logic             rclk,
  input  logic             grst_l,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  fpu_rptr_src_t    in_src_i,
  output logic             in_rdy_o,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_data_o,
  output fpu_rptr_src_t    out_src_o,
  input  logic             out_rdy_i
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  fpu_rptr_src_t    src_q, src_d;
  logic             load;

  always_comb begin
    in_rdy_o = ~vld_q | out_rdy_i;
    load     = in_vld_i & in_rdy_o;
    vld_d    = load | (vld_q & ~out_rdy_i);
    data_d   = load ? in_data_i : data_q;
    src_d    = load ? in_src_i : src_q;
  end

  always_ff @(posedge rclk) begin
    if (!grst_l) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      src_q  <= FPU_RPTR_SRC_ADD;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      src_q  <= src_d;
    end
  end

  assign out_vld_o  = vld_q;
  assign out_data_o = data_q;
  assign out_src_o  = src_q;

endmodule

// File: rtl/fpu_rptr_arb.sv
// Round-robin arbiter plus registered repeater for the shared FPU result bus.
// Define FPU_RPTR_PIPE_EN for two cascaded register stages (latency 2, capacity 2).
module fpu_rptr_arb
  import fpu_rptr_pkg::*;
#(
  parameter int unsigned WIDTH = FPU_RPTR_WIDTH
) (
  input logic            rclk,
  input logic            grst_l,
  fpu_rptr_arb_if.slave  bus
);

  logic [2:0]       req_vld;
  logic [2:0]       gnt;
  logic             load_ok;
  fpu_rptr_src_t    ptr_q, ptr_d;
  fpu_rptr_src_t    cand;
  fpu_rptr_src_t    gnt_src;
  logic [WIDTH-1:0] gnt_data;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  fpu_rptr_src_t    out_src;

  assign req_vld = {bus.div_req_vld, bus.mul_req_vld, bus.add_req_vld};

  // Search starts at the source after the last grant; grants are masked while in reset.
  always_comb begin
    gnt     = '0;
    gnt_src = ptr_q;
    cand    = fpu_rptr_next_src(ptr_q);
    for (int k = 0; k < 3; k++) begin
      if ((gnt == 3'b000) && req_vld[cand]) begin
        gnt[cand] = 1'b1;
        gnt_src   = cand;
      end
      cand = fpu_rptr_next_src(cand);
    end
    gnt   = gnt & {3{load_ok & grst_l}};
    ptr_d = (gnt != 3'b000) ? gnt_src : ptr_q;
  end

  always_comb begin
    case (gnt_src)
      FPU_RPTR_SRC_ADD: gnt_data = bus.add_req_data;
      FPU_RPTR_SRC_MUL: gnt_data = bus.mul_req_data;
      default:          gnt_data = bus.div_req_data;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (!grst_l) begin
      ptr_q <= FPU_RPTR_SRC_DIV;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign bus.add_req_rdy = gnt[0];
  assign bus.mul_req_rdy = gnt[1];
  assign bus.div_req_rdy = gnt[2];

`ifdef FPU_RPTR_PIPE_EN
  logic             s1_vld;
  logic [WIDTH-1:0] s1_data;
  fpu_rptr_src_t    s1_src;
  logic             s1_rdy;

  fpu_rptr_stage #(.WIDTH(WIDTH)) u_stage1 (
    .rclk       (rclk),
    .grst_l     (grst_l),
    .in_vld_i   (|gnt),
    .in_data_i  (gnt_data),
    .in_src_i   (gnt_src),
    .in_rdy_o   (load_ok),
    .out_vld_o  (s1_vld),
    .out_data_o (s1_data),
    .out_src_o  (s1_src),
    .out_rdy_i  (s1_rdy)
  );

  fpu_rptr_stage #(.WIDTH(WIDTH)) u_stage2 (
    .rclk       (rclk),
    .grst_l     (grst_l),
    .in_vld_i   (s1_vld),
    .in_data_i  (s1_data),
    .in_src_i   (s1_src),
    .in_rdy_o   (s1_rdy),
    .out_vld_o  (out_vld),
    .out_data_o (out_data),
    .out_src_o  (out_src),
    .out_rdy_i  (bus.rptr_out_rdy)
  );
`else
  fpu_rptr_stage #(.WIDTH(WIDTH)) u_stage (
    .rclk       (rclk),
    .grst_l     (grst_l),
    .in_vld_i   (|gnt),
    .in_data_i  (gnt_data),
    .in_src_i   (gnt_src),
    .in_rdy_o   (load_ok),
    .out_vld_o  (out_vld),
    .out_data_o (out_data),
    .out_src_o  (out_src),
    .out_rdy_i  (bus.rptr_out_rdy)
  );
`endif

  assign bus.rptr_out_vld  = out_vld;
  assign bus.rptr_out_data = out_data;
  assign bus.rptr_out_src  = out_src;

endmodule
